// File: rtl/valid_ready_round_robin_arbiter.sv
// Round-robin arbiter merging REQUESTERS valid/ready channels onto one sink.
// Define VALID_READY_ARBITER_PACKET_LOCK_EN to hold each grant until the beat with last=1.
module valid_ready_round_robin_arbiter #(
    parameter int WIDTH      = 8,
    parameter int REQUESTERS = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [REQUESTERS*WIDTH-1:0]   request_data,
    input  logic [REQUESTERS-1:0]         request_valid,
    input  logic [REQUESTERS-1:0]         request_last,
    output logic [REQUESTERS-1:0]         request_ready,
    output logic [WIDTH-1:0]              sink_data,
    output logic                          sink_valid,
    output logic                          sink_last,
    input  logic                          sink_ready,
    output logic [$clog2(REQUESTERS)-1:0] grant_index,
    output logic                          busy
);

    localparam int IW = $clog2(REQUESTERS);

    typedef enum logic {ARBITRATE, HOLD} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] idx_q, idx_d;

    logic          found;
    logic [IW-1:0] search_idx;
    logic [IW-1:0] grant;
    logic          have_grant;
    logic          xfer;
    logic          grant_ends;

    // First valid requester at or above the pointer, wrapping to 0.
    always_comb begin
        int unsigned cand;
        found      = 1'b0;
        search_idx = '0;
        cand       = 0;
        for (int unsigned k = 0; k < REQUESTERS; k++) begin
            cand = (32'(ptr_q) + k) % REQUESTERS;
            if (!found && request_valid[IW'(cand)]) begin
                found      = 1'b1;
                search_idx = IW'(cand);
            end
        end
    end

    always_comb begin
        grant      = (state_q == HOLD) ? idx_q : search_idx;
        have_grant = !reset && ((state_q == HOLD) || found);

        sink_data     = '0;
        sink_last     = 1'b0;
        sink_valid    = 1'b0;
        request_ready = '0;
        for (int unsigned i = 0; i < REQUESTERS; i++) begin
            if (grant == IW'(i)) begin
                sink_data  = request_data[i*WIDTH +: WIDTH];
                sink_last  = request_last[i];
                sink_valid = have_grant && request_valid[i];
                request_ready[i] = have_grant && sink_ready;
            end
        end

        grant_index = have_grant ? grant : '0;
        busy        = (state_q == HOLD);
    end

    always_comb begin
        xfer = sink_valid && sink_ready;
`ifdef VALID_READY_ARBITER_PACKET_LOCK_EN
        grant_ends = xfer && sink_last;
`else
        grant_ends = xfer;
`endif
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        if (grant_ends) begin
            state_d = ARBITRATE;
            ptr_d   = (grant == IW'(REQUESTERS - 1)) ? '0 : grant + 1'b1;
        end else if (sink_valid) begin
            // Stalled beat or mid-packet transfer: pin the grant.
            state_d = HOLD;
            idx_d   = grant;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ARBITRATE;
            ptr_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

endmodule
